regfile_rename_mp: RTL and testbench

- Parametrised architectural register file with rename-tag (dirty/ROB-entry) tracking for the out-of-order core.
- Successor to the single-commit, two-read-port file.
- Adds N read ports, M in-order commit ports, a live dirty-register counter, and an optional single-level branch checkpoint.
- Sits between decoder (reads + rename), ROB (commit) and the rollback controller.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_commit_merge.sv | 40 ++++
 rtl/regfile_rename_mp.sv | 131 +++++++++++++
 tb/tb_regfile_rename_mp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, defaults and commit-hit record for the rename register file
package rf_pkg;
  localparam int XLEN_D  = 32;
  localparam int NREG_D  = 32;
  localparam int ROB_W_D = 4;
  function automatic int idx_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction
  typedef struct packed {
    logic                       valid;
    logic [$clog2(NREG_D)-1:0] idx;
    logic [XLEN_D-1:0]         val;
    logic [ROB_W_D-1:0]        tag;
  } cm_hit_t;
endpackage

// File: rtl/rf_commit_merge.sv
// rf_commit_merge: folds NCP in-order commit ports into per-register write/clear vectors
//   i_cm_*  : commit ports, higher index = younger
//   i_dirty/i_tag : live rename tables the tags are matched against
//   o_we/o_val    : per-register write enable and youngest committed value
//   o_clr/o_fval  : per-register clear hit and value of the youngest clearing port
module rf_commit_merge import rf_pkg::*; #(
  parameter int XLEN  = XLEN_D,
  parameter int NREG  = NREG_D,
  parameter int ROB_W = ROB_W_D,
  parameter int NCP   = 2,
  localparam int IW   = idx_w(NREG)
) (
  input  logic [NCP-1:0]             i_cm_valid,
  input  logic [NCP-1:0][IW-1:0]     i_cm_idx,
  input  logic [NCP-1:0][XLEN-1:0]   i_cm_val,
  input  logic [NCP-1:0][ROB_W-1:0]  i_cm_tag,
  input  logic [NREG-1:0]            i_dirty,
  input  logic [NREG-1:0][ROB_W-1:0] i_tag,
  output logic [NREG-1:0]            o_we,
  output logic [NREG-1:0][XLEN-1:0]  o_val,
  output logic [NREG-1:0]            o_clr,
  output logic [NREG-1:0][XLEN-1:0]  o_fval
);
  always_comb begin
    o_we   = '0;
    o_val  = '0;
    o_clr  = '0;
    o_fval = '0;
    for (int p = 0; p < NCP; p++) begin
      if (i_cm_valid[p] && i_cm_idx[p] != '0) begin
        o_we[i_cm_idx[p]]  = 1'b1;
        o_val[i_cm_idx[p]] = i_cm_val[p];
        if (i_dirty[i_cm_idx[p]] && i_tag[i_cm_idx[p]] == i_cm_tag[p]) begin
          o_clr[i_cm_idx[p]]  = 1'b1;
          o_fval[i_cm_idx[p]] = i_cm_val[p];
        end
      end
    end
  end
endmodule

// File: rtl/regfile_rename_mp.sv
// regfile_rename_mp: multi-port architectural register file with rename (dirty/ROB tag) tracking
//   clk, rst (async active-low), rdy (global enable), rollback (flush rename state)
//   rd_idx -> rd_dirty/rd_tag/rd_val : NRP combinational read ports with commit forwarding
//   cm_valid/cm_idx/cm_val/cm_tag    : NCP in-order commit ports, higher index = younger
//   rn_valid/rn_idx/rn_tag           : rename of one destination per cycle
//   dirty_cnt                        : registered count of dirty registers
//   RF_CHECKPOINT_EN adds snap_take/snap_restore and a one-level shadow of the rename tables
module regfile_rename_mp import rf_pkg::*; #(
  parameter int XLEN  = XLEN_D,
  parameter int NREG  = NREG_D,
  parameter int ROB_W = ROB_W_D,
  parameter int NRP   = 2,
  parameter int NCP   = 2,
  localparam int IW   = idx_w(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
`ifdef RF_CHECKPOINT_EN
  input  logic                  snap_take,
  input  logic                  snap_restore,
`endif
  input  logic [NRP*IW-1:0]     rd_idx,
  output logic [NRP-1:0]        rd_dirty,
  output logic [NRP*ROB_W-1:0]  rd_tag,
  output logic [NRP*XLEN-1:0]   rd_val,
  input  logic [NCP-1:0]        cm_valid,
  input  logic [NCP*IW-1:0]     cm_idx,
  input  logic [NCP*XLEN-1:0]   cm_val,
  input  logic [NCP*ROB_W-1:0]  cm_tag,
  input  logic                  rn_valid,
  input  logic [IW-1:0]         rn_idx,
  input  logic [ROB_W-1:0]      rn_tag,
  output logic [IW:0]           dirty_cnt
);
  logic [NREG-1:0][XLEN-1:0]  r_val;
  logic [NREG-1:0]            r_dirty;
  logic [NREG-1:0][ROB_W-1:0] r_tag;
  logic [NREG-1:0]            w_we, w_clr, w_nd;
  logic [NREG-1:0][XLEN-1:0]  w_mval, w_fval;
  logic [NREG-1:0][ROB_W-1:0] w_nt;
  logic [IW:0]                w_cnt;
`ifdef RF_CHECKPOINT_EN
  logic [NREG-1:0]            r_sdirty, w_sclr, w_snd;
  logic [NREG-1:0][ROB_W-1:0] r_stag, w_snt;
`endif

  rf_commit_merge #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NCP(NCP)) u_merge (
    .i_cm_valid(cm_valid),
    .i_cm_idx  (cm_idx),
    .i_cm_val  (cm_val),
    .i_cm_tag  (cm_tag),
    .i_dirty   (r_dirty),
    .i_tag     (r_tag),
    .o_we      (w_we),
    .o_val     (w_mval),
    .o_clr     (w_clr),
    .o_fval    (w_fval)
  );

  // Renames of this cycle are deliberately invisible here; the decoder handles intra-bundle deps
  always_comb begin
    rd_dirty = '0;
    rd_tag   = '0;
    rd_val   = '0;
    for (int k = 0; k < NRP; k++) begin
      automatic logic [IW-1:0] ri = rd_idx[k*IW +: IW];
      rd_dirty[k]               = !w_clr[ri] && r_dirty[ri];
      rd_tag[k*ROB_W +: ROB_W]  = w_clr[ri] ? '0 : r_tag[ri];
      rd_val[k*XLEN +: XLEN]    = w_clr[ri] ? w_fval[ri] : r_val[ri];
    end
  end

  // Next-state rename tables: commit clears, then rename, then flush/restore
  always_comb begin
    w_nd = r_dirty & ~w_clr;
    for (int i = 0; i < NREG; i++) w_nt[i] = w_clr[i] ? '0 : r_tag[i];
    if (rn_valid && rn_idx != '0) begin
      w_nd[rn_idx] = 1'b1;
      w_nt[rn_idx] = rn_tag;
    end
`ifdef RF_CHECKPOINT_EN
    // Shadow entries retire when their own tag commits, so they never go stale
    w_sclr = '0;
    for (int p = 0; p < NCP; p++) begin
      automatic logic [IW-1:0] ci = cm_idx[p*IW +: IW];
      if (cm_valid[p] && ci != '0 && r_sdirty[ci] && r_stag[ci] == cm_tag[p*ROB_W +: ROB_W])
        w_sclr[ci] = 1'b1;
    end
    if (snap_restore) begin
      w_nd = r_sdirty & ~w_sclr & ~w_clr;
      for (int i = 0; i < NREG; i++) w_nt[i] = w_nd[i] ? r_stag[i] : '0;
    end else if (rollback) begin
      w_nd = '0;
      w_nt = '0;
    end
    w_snd = snap_take ? w_nd : (rollback && !snap_restore) ? '0 : r_sdirty & ~w_sclr;
    for (int i = 0; i < NREG; i++) w_snt[i] = snap_take ? w_nt[i] : w_snd[i] ? r_stag[i] : '0;
`else
    if (rollback) begin
      w_nd = '0;
      w_nt = '0;
    end
`endif
    w_cnt = '0;
    for (int i = 0; i < NREG; i++) w_cnt = w_cnt + {{IW{1'b0}}, w_nd[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val     <= '0;
      r_dirty   <= '0;
      r_tag     <= '0;
      dirty_cnt <= '0;
`ifdef RF_CHECKPOINT_EN
      r_sdirty  <= '0;
      r_stag    <= '0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < NREG; i++) if (w_we[i]) r_val[i] <= w_mval[i];
      r_dirty   <= w_nd;
      r_tag     <= w_nt;
      dirty_cnt <= w_cnt;
`ifdef RF_CHECKPOINT_EN
      r_sdirty  <= w_snd;
      r_stag    <= w_snt;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_rename_mp.sv
// tb_regfile_rename_mp: directed self-checking bench for regfile_rename_mp (default parameters)
module tb_regfile_rename_mp;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, rn_valid;
  logic [9:0]  rd_idx;
  logic [1:0]  rd_dirty;
  logic [7:0]  rd_tag;
  logic [63:0] rd_val;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_idx;
  logic [63:0] cm_val;
  logic [7:0]  cm_tag;
  logic [4:0]  rn_idx;
  logic [3:0]  rn_tag;
  logic [5:0]  dirty_cnt;
  int checks = 0;
  int errors = 0;
`ifdef RF_CHECKPOINT_EN
  logic snap_take, snap_restore;
`endif

  regfile_rename_mp dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
`ifdef RF_CHECKPOINT_EN
    .snap_take(snap_take), .snap_restore(snap_restore),
`endif
    .rd_idx(rd_idx), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_val(rd_val),
    .cm_valid(cm_valid), .cm_idx(cm_idx), .cm_val(cm_val), .cm_tag(cm_tag),
    .rn_valid(rn_valid), .rn_idx(rn_idx), .rn_tag(rn_tag), .dirty_cnt(dirty_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cm(input int p, input logic [4:0] idx, input logic [3:0] tag, input logic [31:0] val);
    cm_valid[p]       = 1'b1;
    cm_idx[p*5 +: 5]  = idx;
    cm_tag[p*4 +: 4]  = tag;
    cm_val[p*32 +: 32] = val;
  endtask

  task automatic rn(input logic [4:0] idx, input logic [3:0] tag);
    rn_valid = 1'b1;
    rn_idx   = idx;
    rn_tag   = tag;
  endtask

  task automatic idle();
    cm_valid = '0;
    rn_valid = 1'b0;
    rollback = 1'b0;
`ifdef RF_CHECKPOINT_EN
    snap_take    = 1'b0;
    snap_restore = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; idle();
    cm_idx = '0; cm_val = '0; cm_tag = '0; rn_idx = '0; rn_tag = '0;
    rd_idx = {5'd0, 5'd5};
    #2;
    chk("reset_cnt", 32'(dirty_cnt), 0);
    chk("reset_val", rd_val[31:0], 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    // commit to a clean register: value written, stays clean
    cm(0, 5'd5, 4'd0, 32'h1234);
    step(); idle(); #1;
    chk("clean_commit_val", rd_val[31:0], 32'h1234);
    chk("clean_commit_dirty", 32'(rd_dirty[0]), 0);
    rn(5'd5, 4'd3);
    step(); idle(); #1;
    chk("x5_dirty", 32'(rd_dirty[0]), 1);
    chk("x5_tag", 32'(rd_tag[3:0]), 3);
    chk("x5_cnt", 32'(dirty_cnt), 1);
    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("arst_dirty", 32'(rd_dirty[0]), 0);
    chk("arst_tag", 32'(rd_tag[3:0]), 0);
    chk("arst_val", rd_val[31:0], 0);
    chk("arst_cnt", 32'(dirty_cnt), 0);
    rst = 1'b1;
    // stale-tag commit, then forwarding
    rd_idx = {5'd0, 5'd7};
    rn(5'd7, 4'd2);
    step(); idle();
    chk("x7_cnt", 32'(dirty_cnt), 1);
    cm(0, 5'd7, 4'd9, 32'h77);
    #1;
    chk("stale_nofwd_dirty", 32'(rd_dirty[0]), 1);
    chk("stale_nofwd_tag", 32'(rd_tag[3:0]), 2);
    step(); idle(); #1;
    chk("stale_val", rd_val[31:0], 32'h77);
    chk("stale_dirty", 32'(rd_dirty[0]), 1);
    cm(0, 5'd7, 4'd2, 32'hDEADBEEF);
    #1;
    chk("fwd_dirty", 32'(rd_dirty[0]), 0);
    chk("fwd_tag", 32'(rd_tag[3:0]), 0);
    chk("fwd_val", rd_val[31:0], 32'hDEADBEEF);
    step(); idle(); #1;
    chk("fwd_stored_val", rd_val[31:0], 32'hDEADBEEF);
    chk("fwd_stored_dirty", 32'(rd_dirty[0]), 0);
    chk("fwd_cnt", 32'(dirty_cnt), 0);
    // dual commit to the same register
    rd_idx = {5'd7, 5'd9};
    rn(5'd9, 4'd5);
    step(); idle();
    cm(0, 5'd9, 4'd4, 32'd1);
    cm(1, 5'd9, 4'd5, 32'd2);
    #1;
    chk("dual_fwd_val", rd_val[31:0], 2);
    chk("dual_fwd_dirty", 32'(rd_dirty[0]), 0);
    chk("port1_x7_val", rd_val[63:32], 32'hDEADBEEF);
    step(); idle(); #1;
    chk("dual_val", rd_val[31:0], 2);
    chk("dual_dirty", 32'(rd_dirty[0]), 0);
    rn(5'd9, 4'd5);
    step(); idle();
    cm(0, 5'd9, 4'd5, 32'd1);
    cm(1, 5'd9, 4'd4, 32'd2);
    step(); idle(); #1;
    chk("swap_val", rd_val[31:0], 2);
    chk("swap_dirty", 32'(rd_dirty[0]), 0);
    chk("swap_tag", 32'(rd_tag[3:0]), 0);
    // rename overrides a same-cycle clear of the same register
    rd_idx = {5'd0, 5'd3};
    rn(5'd3, 4'd1);
    step(); idle();
    cm(0, 5'd3, 4'd1, 32'h10);
    rn(5'd3, 4'd6);
    step(); idle(); #1;
    chk("coll_val", rd_val[31:0], 32'h10);
    chk("coll_dirty", 32'(rd_dirty[0]), 1);
    chk("coll_tag", 32'(rd_tag[3:0]), 6);
    chk("coll_cnt", 32'(dirty_cnt), 1);
    // rdy low freezes everything
    rdy = 1'b0;
    rn(5'd10, 4'd1);
    cm(0, 5'd3, 4'd6, 32'h99);
    step(); idle(); rdy = 1'b1; #1;
    chk("frz_val", rd_val[31:0], 32'h10);
    chk("frz_dirty", 32'(rd_dirty[0]), 1);
    chk("frz_cnt", 32'(dirty_cnt), 1);
    // rollback
    for (int i = 1; i <= 4; i++) begin
      rn(5'(i), 4'(i));
      step();
    end
    idle();
    chk("rb_pre_cnt", 32'(dirty_cnt), 4);
    rn(5'd0, 4'd5);
    step(); idle();
    chk("x0_rename_cnt", 32'(dirty_cnt), 4);
    rd_idx = {5'd8, 5'd2};
    rollback = 1'b1;
    cm(0, 5'd2, 4'd2, 32'h55);
    cm(1, 5'd0, 4'd0, 32'hFFFF);
    rn(5'd8, 4'd7);
    step(); idle(); #1;
    chk("rb_cnt", 32'(dirty_cnt), 0);
    chk("rb_x2_val", rd_val[31:0], 32'h55);
    chk("rb_x2_dirty", 32'(rd_dirty[0]), 0);
    chk("rb_x8_dirty", 32'(rd_dirty[1]), 0);
    rd_idx = {5'd3, 5'd0};
    #1;
    chk("x0_val", rd_val[31:0], 0);
    chk("rb_x3_dirty", 32'(rd_dirty[1]), 0);
`ifdef RF_CHECKPOINT_EN
    rd_idx = {5'd6, 5'd4};
    rn(5'd4, 4'd7);
    snap_take = 1'b1;
    step(); idle();
    rn(5'd6, 4'd8);
    step(); idle();
    chk("snap_pre_cnt", 32'(dirty_cnt), 2);
    cm(0, 5'd4, 4'd7, 32'h44);
    step(); idle();
    snap_restore = 1'b1;
    step(); idle(); #1;
    chk("snap_x4_dirty", 32'(rd_dirty[0]), 0);
    chk("snap_x4_tag", 32'(rd_tag[3:0]), 0);
    chk("snap_x4_val", rd_val[31:0], 32'h44);
    chk("snap_x6_dirty", 32'(rd_dirty[1]), 0);
    chk("snap_cnt", 32'(dirty_cnt), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
